a23_gc_stream_host: RTL and testbench
=====================================

# a23_gc_stream_host

Hardware host for the `a23_gc_main` garbled-processor core. It accepts a 32-bit word stream and loads it into the flat `p_init`/`g_init`/`e_init` image buses while holding the core in reset. It then releases the core and counts cycles until `terminate`. Finally it snapshots `o` and streams the output words back out, followed by the cycle count. This is the synthesizable counterpart of the simulation bench flow: load images, run, dump output.

## Interface
- CODE_MEM_SIZE, 64, words in `p_init` (≥1)
- G_MEM_SIZE, 64, words in `g_init` (≥1)
- E_MEM_SIZE, 64, words in `e_init` (≥1)
- OUT_MEM_SIZE, 64, words in `o` (≥1)
- CC_WIDTH, 32, cycle-counter width (≤32)

Ports:
- clk  in  1  single clock, all state on posedge
- rst  in  1  asynchronous, active-high reset
- in_valid  in  1  input word valid
- in_ready  out  1  input word accepted when `in_valid && in_ready`
- in_data  in  32  input word
- p_init  out  CODE_MEM_SIZE*32  code image; word i at [32i+31:32i]
- g_init  out  G_MEM_SIZE*32  garbler input image
- e_init  out  E_MEM_SIZE*32  evaluator input image
- core_rst  out  1  reset to core, active-high
- o  in  OUT_MEM_SIZE*32  core output memory
- terminate  in  1  core finished
- out_valid  out  1  output word valid
- out_ready  in  1  output word consumed when `out_valid && out_ready`
- out_data  out  32  output word
- out_last  out  1  marks final (cycle-count) word
- cc  out  CC_WIDTH  cycles counted in last/current run

## Operation
- States: LOAD_P → LOAD_G → LOAD_E → RUN → DRAIN → LOAD_P.
- LOAD_x: `in_ready=1`. Each accepted word is written to index `widx` of the current image, starting at `widx=0`. After the last index (SIZE-1) is accepted, clear `widx` and advance. Unwritten indices keep their previous value.
- `core_rst=1` in every state except RUN.
- Entering RUN (after the last E word is accepted): clear `cc` to 0.
- RUN, each cycle:
  - `terminate=0`: `cc` increments, saturating at all-ones.
  - `terminate=1`: capture `o` into the snapshot register, clear the read index, go to DRAIN. `cc` does not increment on this cycle.
- `terminate` is ignored outside RUN.
- DRAIN:
  - `out_valid=1`.
  - Words 0..OUT_MEM_SIZE-1 come from the snapshot.
  - Word OUT_MEM_SIZE is `cc`, zero-extended to 32, with `out_last=1`.
  - Index advances only on handshake.
  - After the last word handshakes, return to LOAD_P; images are retained.
- `in_ready=0` and `out_valid=0` wherever not stated above.
- Reset values: state LOAD_P, all indices 0, `p/g/e_init` 0, snapshot 0, `cc` 0, `core_rst` 1, `in_ready` 1, `out_valid` 0, `out_last` 0, `out_data` 0.
- Reset mid-operation: immediate return to reset values; a partial load is discarded (images zeroed).

## Timing
- `in_ready`, `out_valid`, `out_last` and `core_rst` are decoded from registered state only; no combinational input→output paths.
- Throughput: one input word per cycle in LOAD, one output word per cycle in DRAIN.
- `core_rst` falls on the clock edge that accepts the last E word; the core's first active cycle is the next one.
- `terminate` sampled high in the first RUN cycle gives `cc=0`.
- A stalled DRAIN (`out_ready=0`) holds `out_data`/`out_last` stable.
- `in_valid` arriving in RUN/DRAIN is not accepted (back-pressured).
- Latency from `terminate` high to first `out_valid`: 1 cycle.

## Structure
- Package `a23_stream_pkg`:
  - state enum (LOAD_P, LOAD_G, LOAD_E, RUN, DRAIN)
  - `WORD_W=32`
  - index-width function `clog2`
- Sub-module `a23_image_loader` (parameter SIZE): word-indexed write into a flat image register with `we`/`idx`/`wdata`. Instantiated three times (P, G, E).
- Top: FSM, `cc` counter, snapshot register, output mux.

## Test plan
- Reset release, stub core asserting `terminate` 10 cycles after `core_rst` falls, `o` word k = k+0x100 → stream 0x100..0x13F then 0x0000000A with `out_last`.
- Load P=0x0..0x3F, G=0x1000_0000+k, E=0x2000_0000+k with random `in_valid` gaps → `p_init[32k+31:32k]=k`, `g_init`/`e_init` match; `core_rst` stays 1 until the last E word.
- `terminate=1` in the first RUN cycle → `cc=0`, last output word 0x00000000.
- Random `out_ready` stalls in DRAIN → no word dropped or duplicated, data stable while stalled.
- Assert `rst` midway through LOAD_G → all images 0, state LOAD_P, `in_ready=1` the next cycle.
- `terminate` pulsed during LOAD_E, and `in_valid` held high through RUN → neither has any effect; `cc` counts only RUN cycles.

Source files
------------

// File: rtl/a23_stream_pkg.sv
// a23_stream_pkg: shared state encoding, word width and index-width helper for the stream host
package a23_stream_pkg;
    typedef enum logic [2:0] {LOAD_P, LOAD_G, LOAD_E, RUN, DRAIN} state_t;
    localparam int WORD_W = 32;
    function automatic int clog2(input int n);
        int w = 1;
        while ((1 << w) < n) w++;
        return w;
    endfunction
endpackage

// File: rtl/a23_image_loader.sv
// a23_image_loader: word-indexed write port into a flat image register
module a23_image_loader
    import a23_stream_pkg::*;
#(
    parameter int SIZE = 64
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     we,
    input  logic [clog2(SIZE)-1:0]   idx,
    input  logic [WORD_W-1:0]        wdata,
    output logic [SIZE*WORD_W-1:0]   image
);
    always_ff @(posedge clk or posedge rst) begin
        if (rst) image <= '0;
        else if (we) image[idx*WORD_W +: WORD_W] <= wdata;
    end
endmodule

// File: rtl/a23_gc_stream_host.sv
// a23_gc_stream_host: streams images into a23_gc_main, times the run and streams the outputs back
module a23_gc_stream_host
    import a23_stream_pkg::*;
#(
    parameter int CODE_MEM_SIZE = 64,
    parameter int G_MEM_SIZE    = 64,
    parameter int E_MEM_SIZE    = 64,
    parameter int OUT_MEM_SIZE  = 64,
    parameter int CC_WIDTH      = 32
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            in_valid,
    output logic                            in_ready,
    input  logic [WORD_W-1:0]               in_data,
    output logic [CODE_MEM_SIZE*WORD_W-1:0] p_init,
    output logic [G_MEM_SIZE*WORD_W-1:0]    g_init,
    output logic [E_MEM_SIZE*WORD_W-1:0]    e_init,
    output logic                            core_rst,
    input  logic [OUT_MEM_SIZE*WORD_W-1:0]  o,
    input  logic                            terminate,
    output logic                            out_valid,
    input  logic                            out_ready,
    output logic [WORD_W-1:0]               out_data,
    output logic                            out_last,
    output logic [CC_WIDTH-1:0]             cc
);
    localparam int MAX_SIZE = (CODE_MEM_SIZE > G_MEM_SIZE) ?
        ((CODE_MEM_SIZE > E_MEM_SIZE) ? CODE_MEM_SIZE : E_MEM_SIZE) :
        ((G_MEM_SIZE > E_MEM_SIZE) ? G_MEM_SIZE : E_MEM_SIZE);
    localparam int WIW = clog2(MAX_SIZE);
    localparam int RIW = clog2(OUT_MEM_SIZE + 1);
    localparam logic [WIW-1:0] P_LAST = WIW'(CODE_MEM_SIZE - 1);
    localparam logic [WIW-1:0] G_LAST = WIW'(G_MEM_SIZE - 1);
    localparam logic [WIW-1:0] E_LAST = WIW'(E_MEM_SIZE - 1);
    localparam logic [RIW-1:0] R_LAST = RIW'(OUT_MEM_SIZE);

    state_t state, state_nx;
    logic [WIW-1:0] widx;
    logic [RIW-1:0] ridx;
    logic [OUT_MEM_SIZE*WORD_W-1:0] snap;
    logic accept, last_in, out_fire;

    assign in_ready  = state == LOAD_P || state == LOAD_G || state == LOAD_E;
    assign core_rst  = state != RUN;
    assign out_valid = state == DRAIN;
    assign out_last  = out_valid && ridx == R_LAST;
    // The slot past the snapshot carries the cycle count.
    assign out_data  = !out_valid ? '0 : out_last ? WORD_W'(cc) : snap[ridx*WORD_W +: WORD_W];
    assign accept    = in_valid && in_ready;
    assign out_fire  = out_valid && out_ready;
    assign last_in   = (state == LOAD_P && widx == P_LAST) ||
                       (state == LOAD_G && widx == G_LAST) ||
                       (state == LOAD_E && widx == E_LAST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= LOAD_P;
        else state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        if (accept && last_in) state_nx = state == LOAD_P ? LOAD_G : state == LOAD_G ? LOAD_E : RUN;
        if (state == RUN && terminate) state_nx = DRAIN;
        if (out_fire && out_last) state_nx = LOAD_P;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            widx <= '0;
            ridx <= '0;
            snap <= '0;
            cc   <= '0;
        end else begin
            if (accept) widx <= last_in ? '0 : widx + 1'b1;
            if (accept && last_in && state == LOAD_E) cc <= '0;
            if (state == RUN && terminate) begin
                snap <= o;
                ridx <= '0;
            end else if (state == RUN && ~&cc) begin
                cc <= cc + 1'b1;
            end
            if (out_fire) ridx <= out_last ? '0 : ridx + 1'b1;
        end
    end

    a23_image_loader #(.SIZE(CODE_MEM_SIZE)) u_p (
        .clk(clk), .rst(rst), .we(accept && state == LOAD_P),
        .idx(widx[clog2(CODE_MEM_SIZE)-1:0]), .wdata(in_data), .image(p_init)
    );
    a23_image_loader #(.SIZE(G_MEM_SIZE)) u_g (
        .clk(clk), .rst(rst), .we(accept && state == LOAD_G),
        .idx(widx[clog2(G_MEM_SIZE)-1:0]), .wdata(in_data), .image(g_init)
    );
    a23_image_loader #(.SIZE(E_MEM_SIZE)) u_e (
        .clk(clk), .rst(rst), .we(accept && state == LOAD_E),
        .idx(widx[clog2(E_MEM_SIZE)-1:0]), .wdata(in_data), .image(e_init)
    );
endmodule

// File: tb/tb_a23_gc_stream_host.sv
// tb_a23_gc_stream_host: directed load/run/drain scenarios checked through an output scoreboard
`timescale 1ns/1ps
module tb_a23_gc_stream_host;
    localparam int N = 64;

    logic clk = 0, rst = 1, in_valid = 0, terminate = 0, out_ready = 1;
    logic [31:0] in_data = 0;
    logic [N*32-1:0] o = '0;
    logic in_ready, core_rst, out_valid, out_last;
    logic [N*32-1:0] p_init, g_init, e_init;
    logic [31:0] out_data, cc;

    int nvec = 0, nerr = 0;
    bit rnd_ready = 0, rnd_gap = 0;

    typedef struct packed { logic [31:0] d; logic l; } exp_t;
    exp_t q[$];

    a23_gc_stream_host dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .p_init(p_init), .g_init(g_init), .e_init(e_init), .core_rst(core_rst), .o(o),
        .terminate(terminate), .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_last(out_last), .cc(cc)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %h, expected %h", nm, act, exp);
        end
    endtask

    // Scoreboard monitor: while valid, the head entry must be presented; pop on handshake.
    always @(negedge clk) begin
        if (out_valid) begin
            if (q.size() == 0) begin
                nvec++;
                nerr++;
                $display("FAIL out_extra: got %h, expected no word", out_data);
            end else begin
                chk("out_data", out_data, q[0].d);
                chk("out_last", 32'(out_last), 32'(q[0].l));
                if (out_ready) void'(q.pop_front());
            end
        end
    end

    always @(posedge clk) begin
        #1;
        out_ready = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1);
    end

    task automatic send(input logic [31:0] d);
        if (rnd_gap) repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
        in_valid = 1;
        in_data = d;
        for (int t = 0; !in_ready; t++) begin
            if (t > 50) begin
                chk("in_ready_wait", 32'(in_ready), 32'd1);
                break;
            end
            @(posedge clk); #1;
        end
        @(posedge clk); #1;
        in_valid = 0;
    endtask

    task automatic send_range(input logic [31:0] base, input int from, input int to);
        for (int k = from; k < to; k++) begin
            if (base[31:28] == 4'h2 && k == N - 1) chk("core_rst_before_last_e", 32'(core_rst), 32'd1);
            send(base + 32'(k));
        end
    endtask

    task automatic chk_img(input string nm, input logic [N*32-1:0] img, input logic [31:0] base);
        for (int k = 0; k < N; k++) chk(nm, img[32*k +: 32], base + 32'(k));
    endtask

    task automatic run_and_drain(input int cycles, input int exp_cc, input logic [31:0] obase);
        for (int k = 0; k < N; k++) begin
            o[32*k +: 32] = obase + 32'(k);
            q.push_back('{d: obase + 32'(k), l: 1'b0});
        end
        q.push_back('{d: 32'(exp_cc), l: 1'b1});
        repeat (cycles) begin @(posedge clk); #1; end
        terminate = 1;
        @(posedge clk); #1;
        terminate = 0;
        chk("first_out_latency", 32'(out_valid), 32'd1);
        chk("cc_at_terminate", cc, 32'(exp_cc));
        o = ~o;
        for (int t = 0; q.size() != 0; t++) begin
            if (t > 2000) begin
                chk("drain_timeout", 32'(q.size()), 32'd0);
                q.delete();
                break;
            end
            @(posedge clk); #1;
        end
        @(posedge clk); #1;
        chk("back_to_load_p", 32'(in_ready), 32'd1);
        chk("drain_done_valid", 32'(out_valid), 32'd0);
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1;
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_core_rst", 32'(core_rst), 32'd1);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_last", 32'(out_last), 32'd0);
        chk("rst_out_data", out_data, 32'd0);
        chk("rst_cc", cc, 32'd0);
        chk("rst_p_zero", 32'(|p_init), 32'd0);
        rst = 0;

        // Gapped load, stub core terminates 10 cycles after release, drain without stalls.
        rnd_gap = 1;
        send_range(32'h0000_0000, 0, N);
        send_range(32'h1000_0000, 0, N);
        send_range(32'h2000_0000, 0, N);
        chk("core_rst_run", 32'(core_rst), 32'd0);
        chk("in_ready_run", 32'(in_ready), 32'd0);
        chk_img("p_img", p_init, 32'h0000_0000);
        chk_img("g_img", g_init, 32'h1000_0000);
        chk_img("e_img", e_init, 32'h2000_0000);
        run_and_drain(10, 10, 32'h100);

        // Immediate terminate, random output stalls.
        rnd_gap = 0;
        rnd_ready = 1;
        send_range(32'h0400_0000, 0, N);
        send_range(32'h1400_0000, 0, N);
        send_range(32'h2400_0000, 0, N);
        run_and_drain(0, 0, 32'h5000_0000);
        chk("cc_zero", cc, 32'd0);

        // Terminate during LOAD_E and in_valid through RUN are ignored.
        send_range(32'h0800_0000, 0, N);
        send_range(32'h1800_0000, 0, N);
        send_range(32'h2800_0000, 0, 30);
        terminate = 1;
        @(posedge clk); #1;
        terminate = 0;
        chk("term_in_load_ready", 32'(in_ready), 32'd1);
        chk("term_in_load_valid", 32'(out_valid), 32'd0);
        send_range(32'h2800_0000, 30, N);
        in_valid = 1;
        in_data = 32'hDEAD_BEEF;
        repeat (5) begin
            chk("run_backpressure", 32'(in_ready), 32'd0);
            @(posedge clk); #1;
        end
        in_valid = 0;
        run_and_drain(3, 8, 32'h6000_0000);
        chk_img("p_retained", p_init, 32'h0800_0000);
        chk_img("e_retained", e_init, 32'h2800_0000);

        // Reset in the middle of LOAD_G discards everything.
        rnd_ready = 0;
        send_range(32'h0C00_0000, 0, N);
        send_range(32'h1C00_0000, 0, 10);
        rst = 1;
        @(posedge clk); #1;
        chk("midrst_p", 32'(|p_init), 32'd0);
        chk("midrst_g", 32'(|g_init), 32'd0);
        chk("midrst_e", 32'(|e_init), 32'd0);
        chk("midrst_in_ready", 32'(in_ready), 32'd1);
        chk("midrst_core_rst", 32'(core_rst), 32'd1);
        chk("midrst_cc", cc, 32'd0);
        rst = 0;
        send(32'hABCD_0123);
        chk("post_rst_p0", p_init[31:0], 32'hABCD_0123);
        chk("post_rst_g0", g_init[31:0], 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule
